// File: rtl/snake_pixel_gen.sv
// rtl/snake_pixel_gen.sv - snake body store, mover/collision logic and registered pixel classifier
// Optional: define SNAKE_WRAP_EN for wrap-around edges (no wall cells, no wall deaths).
module snake_pixel_gen #(
  parameter int MAX_LEN   = 16,
  parameter int INIT_LEN  = 3,
  parameter int GRID_W    = 40,
  parameter int GRID_H    = 30,
  parameter int BLK_SHIFT = 4,
  localparam int LW       = $clog2(MAX_LEN + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    state,
  input  logic          move_tick,
  input  logic [1:0]    dir,
  input  logic [11:0]   EggPos,
  input  logic [9:0]    X_Pos,
  input  logic [9:0]    Y_Pos,
  output logic [2:0]    pixel,
  output logic          egg_eaten,
  output logic          dead,
  output logic [LW-1:0] length
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;
  localparam int X_LIMIT = GRID_W << BLK_SHIFT;
  localparam int Y_LIMIT = GRID_H << BLK_SHIFT;

  localparam logic [2:0] PIX_BG   = 3'd0;
  localparam logic [2:0] PIX_WALL = 3'd1;
  localparam logic [2:0] PIX_HEAD = 3'd2;
  localparam logic [2:0] PIX_BODY = 3'd3;
  localparam logic [2:0] PIX_EGG  = 3'd4;

  logic [5:0] seg_col [MAX_LEN];
  logic [5:0] seg_row [MAX_LEN];
  logic [1:0] heading, pending;

  logic [1:0] eff_dir;
  logic [5:0] nxt_col, nxt_row;
  logic       move_ok, grow, wall_hit, self_hit;

  logic [5:0] px_col, px_row;
  logic       in_area, hit_head, hit_body, hit_egg, hit_wall;
  logic [2:0] pix_next;

  // Opposite headings differ only in bit 0, so a reversal request keeps the current heading.
  always_comb begin
    eff_dir = (pending == {heading[1], ~heading[0]}) ? heading : pending;
    nxt_col = seg_col[0];
    nxt_row = seg_row[0];
    case (eff_dir)
      DIR_UP: begin
        nxt_row = seg_row[0] - 6'd1;
`ifdef SNAKE_WRAP_EN
        if (seg_row[0] == 6'd0) nxt_row = 6'(GRID_H - 1);
`endif
      end
      DIR_DOWN: begin
        nxt_row = seg_row[0] + 6'd1;
`ifdef SNAKE_WRAP_EN
        if (seg_row[0] == 6'(GRID_H - 1)) nxt_row = 6'd0;
`endif
      end
      DIR_LEFT: begin
        nxt_col = seg_col[0] - 6'd1;
`ifdef SNAKE_WRAP_EN
        if (seg_col[0] == 6'd0) nxt_col = 6'(GRID_W - 1);
`endif
      end
      default: begin
        nxt_col = seg_col[0] + 6'd1;
`ifdef SNAKE_WRAP_EN
        if (seg_col[0] == 6'(GRID_W - 1)) nxt_col = 6'd0;
`endif
      end
    endcase

    move_ok = move_tick && (state == ST_RUN) && !dead;
    grow    = ({nxt_col, nxt_row} == EggPos);
`ifdef SNAKE_WRAP_EN
    wall_hit = 1'b0;
`else
    wall_hit = (nxt_col == 6'd0) || (nxt_col == 6'(GRID_W - 1)) ||
               (nxt_row == 6'd0) || (nxt_row == 6'(GRID_H - 1));
`endif
    // The tail vacates its cell on a normal move, so it only blocks when the snake grows.
    self_hit = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((((i + 1) < int'(length)) || (grow && ((i + 1) == int'(length)))) &&
          (seg_col[i] == nxt_col) && (seg_row[i] == nxt_row))
        self_hit = 1'b1;
    end
  end

  always_comb begin
    in_area  = (int'(X_Pos) < X_LIMIT) && (int'(Y_Pos) < Y_LIMIT);
    px_col   = X_Pos[BLK_SHIFT +: 6];
    px_row   = Y_Pos[BLK_SHIFT +: 6];
    hit_head = (seg_col[0] == px_col) && (seg_row[0] == px_row);
    hit_body = 1'b0;
    for (int i = 1; i < MAX_LEN; i++) begin
      if ((i < int'(length)) && (seg_col[i] == px_col) && (seg_row[i] == px_row))
        hit_body = 1'b1;
    end
    hit_egg = ({px_col, px_row} == EggPos);
`ifdef SNAKE_WRAP_EN
    hit_wall = 1'b0;
`else
    hit_wall = (px_col == 6'd0) || (px_col == 6'(GRID_W - 1)) ||
               (px_row == 6'd0) || (px_row == 6'(GRID_H - 1));
`endif
    pix_next = PIX_BG;
    if (!in_area)      pix_next = PIX_BG;
    else if (hit_head) pix_next = PIX_HEAD;
    else if (hit_body) pix_next = PIX_BODY;
    else if (hit_egg)  pix_next = PIX_EGG;
    else if (hit_wall) pix_next = PIX_WALL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_col[i] <= 6'(GRID_W / 2 - i);
        seg_row[i] <= 6'(GRID_H / 2);
      end
      heading   <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      length    <= LW'(INIT_LEN);
      pixel     <= PIX_BG;
      egg_eaten <= 1'b0;
      dead      <= 1'b0;
    end else if (state == ST_IDLE) begin
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_col[i] <= 6'(GRID_W / 2 - i);
        seg_row[i] <= 6'(GRID_H / 2);
      end
      heading   <= DIR_RIGHT;
      pending   <= DIR_RIGHT;
      length    <= LW'(INIT_LEN);
      pixel     <= PIX_BG;
      egg_eaten <= 1'b0;
      dead      <= 1'b0;
    end else begin
      pending   <= dir;
      pixel     <= pix_next;
      egg_eaten <= 1'b0;
      if (move_ok) begin
        if (wall_hit || self_hit) begin
          dead <= 1'b1;
        end else begin
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_col[i] <= seg_col[i-1];
            seg_row[i] <= seg_row[i-1];
          end
          seg_col[0] <= nxt_col;
          seg_row[0] <= nxt_row;
          heading    <= eff_dir;
          if (grow) begin
            egg_eaten <= 1'b1;
            if (int'(length) < MAX_LEN) length <= length + LW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_snake_pixel_gen.sv
// tb/tb_snake_pixel_gen.sv - directed self-checking bench for snake_pixel_gen
module tb_snake_pixel_gen;

  logic        clk;
  logic        rst;
  logic [1:0]  state;
  logic        move_tick;
  logic [1:0]  dir;
  logic [11:0] EggPos;
  logic [9:0]  X_Pos;
  logic [9:0]  Y_Pos;
  logic [2:0]  pixel;
  logic        egg_eaten;
  logic        dead;
  logic [4:0]  length;

  int total  = 0;
  int passed = 0;

  snake_pixel_gen dut (
    .clk       (clk),
    .rst       (rst),
    .state     (state),
    .move_tick (move_tick),
    .dir       (dir),
    .EggPos    (EggPos),
    .X_Pos     (X_Pos),
    .Y_Pos     (Y_Pos),
    .pixel     (pixel),
    .egg_eaten (egg_eaten),
    .dead      (dead),
    .length    (length)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_xy(input string tag, input int x, input int y, input int exp);
    @(negedge clk);
    X_Pos = 10'(x);
    Y_Pos = 10'(y);
    @(negedge clk);
    chk(tag, 32'(pixel), 32'(exp));
  endtask

  task automatic check_pix(input string tag, input int col, input int row, input int exp);
    check_xy(tag, col * 16, row * 16, exp);
  endtask

  // dir must be set before calling: one rising edge passes before move_tick is raised.
  task automatic tick();
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  initial begin
    rst = 1'b0; state = 2'b00; move_tick = 1'b0; dir = 2'b11;
    EggPos = {6'd5, 6'd5}; X_Pos = 10'd0; Y_Pos = 10'd0;
    repeat (2) @(negedge clk);
    chk("rst_pixel", 32'(pixel), 0);
    chk("rst_egg", 32'(egg_eaten), 0);
    chk("rst_dead", 32'(dead), 0);
    chk("rst_length", 32'(length), 3);
    rst = 1'b1;
    check_pix("idle_pixel_forced_bg", 20, 15, 0);

    state = 2'b01;
    check_xy("head_320_240", 320, 240, 2);
    check_xy("body_304_240", 304, 240, 3);
    check_pix("body_18_15", 18, 15, 3);
    check_pix("beyond_tail_17_15", 17, 15, 0);
`ifdef SNAKE_WRAP_EN
    check_pix("corner_no_wall", 0, 0, 0);
`else
    check_pix("corner_wall", 0, 0, 1);
`endif
    check_pix("egg_5_5", 5, 5, 4);
    check_xy("x_blank_700", 700, 240, 0);

    dir = 2'b10;
    repeat (4) tick();
    check_pix("t2_head_24", 24, 15, 2);
    check_pix("t2_body_23", 23, 15, 3);
    check_pix("t2_tail_22", 22, 15, 3);
    check_pix("t2_vacated_21", 21, 15, 0);
    chk("t2_length", 32'(length), 3);

    dir = 2'b11;
    EggPos = {6'd25, 6'd15};
    check_pix("t3_egg_visible", 25, 15, 4);
    tick();
    chk("t3_egg_pulse", 32'(egg_eaten), 1);
    chk("t3_length_grow", 32'(length), 4);
    @(negedge clk);
    chk("t3_egg_pulse_end", 32'(egg_eaten), 0);
    EggPos = {6'd1, 6'd1};
    check_pix("t3_head_25", 25, 15, 2);
    check_pix("t3_tail_kept_22", 22, 15, 3);
    check_pix("t3_vacated_21", 21, 15, 0);

    dir = 2'b00;
    tick();
    check_pix("turn_up_head", 25, 14, 2);
    check_pix("turn_up_neck", 25, 15, 3);
    dir = 2'b11;
    repeat (13) tick();
    check_pix("run_head_38", 38, 14, 2);
    chk("run_alive_38", 32'(dead), 0);
    tick();
`ifdef SNAKE_WRAP_EN
    chk("wrap_alive_39", 32'(dead), 0);
    check_pix("wrap_head_39", 39, 14, 2);
    tick();
    chk("wrap_alive_0", 32'(dead), 0);
    check_pix("wrap_head_0", 0, 14, 2);
    check_pix("wrap_corner_bg", 0, 0, 0);
`else
    chk("wall_dead", 32'(dead), 1);
    check_pix("wall_head_frozen", 38, 14, 2);
    check_pix("wall_cell", 39, 14, 1);
    tick();
    check_pix("dead_tick_ignored", 38, 14, 2);
    chk("dead_sticky", 32'(dead), 1);
    chk("dead_length", 32'(length), 4);
`endif

    state = 2'b00;
    @(negedge clk);
    chk("restart_dead", 32'(dead), 0);
    chk("restart_length", 32'(length), 3);

    state = 2'b10;
    dir = 2'b11;
    repeat (2) tick();
    check_pix("pause_head_still", 20, 15, 2);
    check_pix("pause_no_advance", 21, 15, 0);
    check_xy("y_blank_500", 320, 500, 0);

    state = 2'b01;
    EggPos = {6'd21, 6'd15};
    tick();
    chk("self_grow_pulse", 32'(egg_eaten), 1);
    chk("self_grow_length", 32'(length), 4);
    EggPos = {6'd1, 6'd1};
    dir = 2'b00;
    tick();
    dir = 2'b10;
    tick();
    dir = 2'b01;
    tick();
    chk("tail_chase_alive", 32'(dead), 0);
    check_pix("tail_chase_head", 20, 15, 2);
    dir = 2'b11;
    EggPos = {6'd21, 6'd15};
    tick();
    chk("tail_grow_dead", 32'(dead), 1);
    chk("tail_grow_length", 32'(length), 4);
    chk("tail_grow_no_pulse", 32'(egg_eaten), 0);
    check_pix("tail_grow_head_frozen", 20, 15, 2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
